fetch_unit: RTL and testbench

Program-counter and next-address stage that feeds the instruction ROM and consumes the control decoder's branch outputs (BranchEn, Jump, LUTSel, TargSel, Ack). It holds the architectural PC and sequences start and halt. It resolves sequential, PC-relative and LUT-indirect next addresses. It also owns the 64-entry branch-target LUT, which software or the testbench loads before a run.

---
 rtl/fetch_unit.sv | 152 +++++++++++++++
 tb/tb_fetch_unit.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Fetch stage: holds the PC, sequences IDLE/RUN/HALT and owns the 64-entry branch-target LUT.
// Optional retired-instruction counter (InstrCnt port) is enabled by defining FETCH_ICNT_EN.
module fetch_unit #(
  parameter int PC_W  = 10,
  parameter int OFF_W = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [PC_W-1:0]  StartAddr,
  input  logic             Stall,
  input  logic             BranchEn,
  input  logic             Jump,
  input  logic [1:0]       LUTSel,
  input  logic [3:0]       TargSel,
  input  logic             Ack,
  input  logic             Taken,
  input  logic [OFF_W-1:0] RelOffset,
  input  logic             LutWrEn,
  input  logic [5:0]       LutWrAddr,
  input  logic [PC_W-1:0]  LutWrData,
  output logic [PC_W-1:0]  ProgCtr,
  output logic             Busy,
  output logic             Done
`ifdef FETCH_ICNT_EN
  ,
  output logic [15:0]      InstrCnt
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [PC_W-1:0]   lut_q [64];
  logic [PC_W-1:0]   lut_d [64];
  logic [PC_W-1:0]   lut_rd_s;
  logic [PC_W-1:0]   rel_ext_s;
  logic              start_acc_s;
  logic              run_adv_s;

  // Old LUT contents are read here, so a same-cycle write never affects a jump.
  assign lut_rd_s    = lut_q[{LUTSel, TargSel}];
  assign rel_ext_s   = {{(PC_W-OFF_W){RelOffset[OFF_W-1]}}, RelOffset};
  assign start_acc_s = Start && ((state_q == IDLE) || (state_q == HALT));
  assign run_adv_s   = (state_q == RUN) && !Stall;

  // LUT next-state: synchronous write, legal in any state.
  always_comb begin
    lut_d = lut_q;
    if (LutWrEn) begin
      lut_d[LutWrAddr] = LutWrData;
    end else begin
      lut_d = lut_q;
    end
  end

  // Next-state, next-PC and registered status outputs.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      IDLE, HALT: begin
        if (Start) begin
          state_d = RUN;
          pc_d    = StartAddr;
        end else begin
          state_d = state_q;
        end
      end
      RUN: begin
        if (Stall) begin
          state_d = RUN;
        end else if (Ack) begin
          state_d = HALT;
        end else if (BranchEn && Taken && Jump) begin
          pc_d = lut_rd_s;
        end else if (BranchEn && Taken) begin
          pc_d = pc_q + rel_ext_s;
        end else begin
          pc_d = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d = IDLE;
        pc_d    = pc_q;
      end
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == HALT);
  end

  // State, PC, status and LUT registers.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < 64; i++) begin
        lut_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      lut_q   <= lut_d;
    end
  end

  assign ProgCtr = pc_q;
  assign Busy    = busy_q;
  assign Done    = done_q;

`ifdef FETCH_ICNT_EN
  logic [15:0] cnt_q, cnt_d;

  // Retired count: the Ack cycle counts; saturates rather than wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (start_acc_s) begin
      cnt_d = 16'd0;
    end else if (run_adv_s && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign InstrCnt = cnt_q;
`else
  logic unused_s;
  assign unused_s = start_acc_s ^ run_adv_s;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit; InstrCnt checks are active when FETCH_ICNT_EN is defined.
module tb_fetch_unit;
  logic        Clk = 1'b0;
  logic        Reset;
  logic        Start;
  logic [9:0]  StartAddr;
  logic        Stall;
  logic        BranchEn;
  logic        Jump;
  logic [1:0]  LUTSel;
  logic [3:0]  TargSel;
  logic        Ack;
  logic        Taken;
  logic [7:0]  RelOffset;
  logic        LutWrEn;
  logic [5:0]  LutWrAddr;
  logic [9:0]  LutWrData;
  logic [9:0]  ProgCtr;
  logic        Busy;
  logic        Done;
  logic [15:0] instr_cnt;

  int errors = 0;
  int checks = 0;

  fetch_unit #(.PC_W(10), .OFF_W(8)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .StartAddr(StartAddr), .Stall(Stall),
    .BranchEn(BranchEn), .Jump(Jump), .LUTSel(LUTSel), .TargSel(TargSel), .Ack(Ack),
    .Taken(Taken), .RelOffset(RelOffset), .LutWrEn(LutWrEn), .LutWrAddr(LutWrAddr),
    .LutWrData(LutWrData), .ProgCtr(ProgCtr), .Busy(Busy), .Done(Done)
`ifdef FETCH_ICNT_EN
    , .InstrCnt(instr_cnt)
`endif
  );

`ifndef FETCH_ICNT_EN
  assign instr_cnt = 16'd0;
`endif

  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_st(input string tag, input logic [9:0] pc, input logic b, input logic d);
    check({tag, "_pc"}, {22'd0, ProgCtr}, {22'd0, pc});
    check({tag, "_busy"}, {31'd0, Busy}, {31'd0, b});
    check({tag, "_done"}, {31'd0, Done}, {31'd0, d});
  endtask

  task automatic check_cnt(input string tag, input logic [15:0] exp);
`ifdef FETCH_ICNT_EN
    check({tag, "_cnt"}, {16'd0, instr_cnt}, {16'd0, exp});
`endif
  endtask

  initial begin
    Reset = 1'b0; Start = 1'b0; StartAddr = 10'd0; Stall = 1'b0; BranchEn = 1'b0;
    Jump = 1'b0; LUTSel = 2'd0; TargSel = 4'd0; Ack = 1'b0; Taken = 1'b0;
    RelOffset = 8'd0; LutWrEn = 1'b0; LutWrAddr = 6'd0; LutWrData = 10'd0;
    step(); step();
    check_st("reset", 10'h000, 1'b0, 1'b0);
    check_cnt("reset", 16'd0);
    Reset = 1'b1;

    // Load LUT in IDLE
    LutWrEn = 1'b1; LutWrAddr = 6'd5; LutWrData = 10'h155;
    step();
    LutWrAddr = 6'h23; LutWrData = 10'h3A0;
    step();
    LutWrEn = 1'b0;
    check_st("idle_hold", 10'h000, 1'b0, 1'b0);

    // Sequential run, halt on fourth instruction
    Start = 1'b1; StartAddr = 10'h010;
    step(); Start = 1'b0;
    check_st("start", 10'h010, 1'b1, 1'b0);
    step(); check("seq1", {22'd0, ProgCtr}, 32'h011);
    step(); check("seq2", {22'd0, ProgCtr}, 32'h012);
    step(); check("seq3", {22'd0, ProgCtr}, 32'h013);
    Ack = 1'b1;
    step(); Ack = 1'b0;
    check_st("halt", 10'h013, 1'b0, 1'b1);
    check_cnt("halt", 16'd4);
    step();
    check_st("halt_hold", 10'h013, 1'b0, 1'b1);

    // Restart from HALT, relative branches
    Start = 1'b1; StartAddr = 10'h020;
    step(); Start = 1'b0;
    check_st("restart", 10'h020, 1'b1, 1'b0);
    check_cnt("restart", 16'd0);
    BranchEn = 1'b1; Taken = 1'b1; Jump = 1'b0; RelOffset = 8'hFB;
    step(); check("rel_m5", {22'd0, ProgCtr}, 32'h01B);
    RelOffset = 8'h05;
    step(); check("rel_p5", {22'd0, ProgCtr}, 32'h020);
    Taken = 1'b0;
    step(); check("not_taken", {22'd0, ProgCtr}, 32'h021);

    // LUT jump with same-cycle rewrite, then new value next cycle
    Taken = 1'b1; Jump = 1'b1; LUTSel = 2'd2; TargSel = 4'd3;
    LutWrEn = 1'b1; LutWrAddr = 6'h23; LutWrData = 10'h111;
    step(); LutWrEn = 1'b0;
    check("lut_rbw", {22'd0, ProgCtr}, 32'h3A0);
    step(); check("lut_new", {22'd0, ProgCtr}, 32'h111);
    Jump = 1'b0; RelOffset = 8'h00;
    step(); check("rel_self", {22'd0, ProgCtr}, 32'h111);

    // Wrap cases
    BranchEn = 1'b0; Taken = 1'b0;
    LutWrEn = 1'b1; LutWrAddr = 6'd0; LutWrData = 10'h3FF;
    step(); LutWrEn = 1'b0;
    check("seq_w", {22'd0, ProgCtr}, 32'h112);
    BranchEn = 1'b1; Taken = 1'b1; Jump = 1'b1; LUTSel = 2'd0; TargSel = 4'd0;
    step(); check("lut_3ff", {22'd0, ProgCtr}, 32'h3FF);
    BranchEn = 1'b0; Taken = 1'b0; Jump = 1'b0;
    step(); check("wrap_inc", {22'd0, ProgCtr}, 32'h000);
    step(); step(); check("pc_002", {22'd0, ProgCtr}, 32'h002);
    BranchEn = 1'b1; Taken = 1'b1; RelOffset = 8'h80;
    step(); check("rel_m128", {22'd0, ProgCtr}, 32'h382);
    RelOffset = 8'h7F;
    step(); check("rel_wrap_up", {22'd0, ProgCtr}, 32'h001);
    BranchEn = 1'b0; Taken = 1'b0;

    // Start ignored in RUN
    Start = 1'b1; StartAddr = 10'h2AA;
    step();
    check_st("start_in_run", 10'h002, 1'b1, 1'b0);
    check_cnt("start_in_run", 16'd14);

    // Stall with Ack, Start and branch present
    Stall = 1'b1; Ack = 1'b1; BranchEn = 1'b1; Taken = 1'b1; RelOffset = 8'h10;
    step(); check_st("stall1", 10'h002, 1'b1, 1'b0);
    step(); check_st("stall2", 10'h002, 1'b1, 1'b0);
    step(); check_st("stall3", 10'h002, 1'b1, 1'b0);
    check_cnt("stall", 16'd14);
    Stall = 1'b0; Start = 1'b0;
    step(); Ack = 1'b0; BranchEn = 1'b0; Taken = 1'b0;
    check_st("ack_after_stall", 10'h002, 1'b0, 1'b1);
    check_cnt("ack_after_stall", 16'd15);

    // Restart from HALT to 0x123, then reset mid-run
    Start = 1'b1; StartAddr = 10'h123;
    step(); Start = 1'b0;
    check_st("restart2", 10'h123, 1'b1, 1'b0);
    check_cnt("restart2", 16'd0);
    Reset = 1'b0;
    #1;
    check_st("async_reset", 10'h000, 1'b0, 1'b0);
    check_cnt("async_reset", 16'd0);
    step();
    Reset = 1'b1;

    // LUT cleared by reset
    Start = 1'b1; StartAddr = 10'h0F0;
    step(); Start = 1'b0;
    check_st("post_reset_start", 10'h0F0, 1'b1, 1'b0);
    BranchEn = 1'b1; Taken = 1'b1; Jump = 1'b1; LUTSel = 2'd0; TargSel = 4'd5;
    step(); check("lut5_cleared", {22'd0, ProgCtr}, 32'h000);
    Taken = 1'b0;
    step(); check("seq_after", {22'd0, ProgCtr}, 32'h001);
    Taken = 1'b1; LUTSel = 2'd2; TargSel = 4'd3;
    step(); check("lut23_cleared", {22'd0, ProgCtr}, 32'h000);
    BranchEn = 1'b0; Taken = 1'b0; Jump = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
